ntt_sched: RTL
==============

# ntt_sched

Control sequencer for the Kyber NTT/INTT datapath: it walks the 7 layers of a 256-point transform and issues one butterfly per cycle to the coefficient RAM and the butterfly unit. For each butterfly it generates the coefficient read addresses, the twiddle index, and the butterfly mode. It then returns the write-back addresses, delayed to line up with the butterfly results. Driven by a start/done handshake from the polynomial-arithmetic top level.

## Interface
- RD_LAT, 1, cycles from rd_en to operands valid at butterfly a/b inputs
- BF_LAT, 3, cycles from operands at butterfly inputs to c/d valid
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a transform, sampled only in IDLE
- inv  input  1  0 = forward NTT (Cooley-Tukey), 1 = inverse (Gentleman-Sande), sampled with start
- busy  output  1  high from first issue cycle through last write-back
- done  output  1  one-cycle pulse after final write-back
- rd_en  output  1  coefficient pair read strobe
- rd_addr_a / rd_addr_b  output  8  coefficient indices j and j+len
- tw_idx  output  7  twiddle ROM index, delayed RD_LAT cycles after rd_en to align with operands
- bf_mode  output  2  2'b00 NTT, 2'b01 INTT, 2'b11 idle
- wr_en  output  1  write-back strobe for butterfly c/d
- wr_addr_a / wr_addr_b  output  8  destinations for c and d

## Operation
- L = RD_LAT + BF_LAT.
- States:
  - IDLE: start=1 latches inv and goes to ISSUE with layer=0, p=0.
  - ISSUE: 128 cycles, p = 0..127, rd_en=1. After p=127, go to DRAIN.
  - DRAIN: L cycles, rd_en=0, with a countdown. At expiry, go to ISSUE with layer+1 and p=0. After layer 6, go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Layer-to-s mapping:
  - NTT: layer 0..6 uses s = 7..1.
  - INTT: layer 0..6 uses s = 1..7.
  - In both cases len = 2^s.
- Addresses: rd_addr_a = ((p >> s) << (s+1)) | (p & (len-1)); rd_addr_b = rd_addr_a + len. All values are 8-bit, with no overflow by construction.
- Twiddle index:
  - NTT: k = 2^(7-s) + (p >> s), range 1..127.
  - INTT: k = 2^(8-s) - 1 - (p >> s), range 127..1.
  - k = 0 is never issued.
- bf_mode is constant for the whole transform (00 or 01 per latched inv) from the ISSUE entry through FIN. It is 2'b11 in IDLE.
- Write-back pipeline: an L-deep shift register carries {valid, addr_a, addr_b}. wr_en and wr_addr_a/b come from the tail, so each write is exactly L cycles after its rd_en.
- DRAIN enforces read-after-write between layers: the first read of layer n+1 occurs one cycle after the last write of layer n.
- start while not IDLE: ignored. inv changes mid-transform: ignored.
- Twiddle values, Montgomery scaling and the final INTT n^-1 multiply are outside this block.

## Timing
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, all addresses 0, tw_idx=0, bf_mode=2'b11. All counters and pipeline valids are cleared; state is IDLE.
- Reset asserted mid-transform: everything clears immediately and no further wr_en is issued. A restart needs a new start.
- Cycle numbering: start sampled high at cycle 0.
  - Layer i issues at cycles 1+i(128+L) through 128+i(128+L).
  - Its writes occur at cycles 1+L+i(128+L) through (i+1)(128+L).
- busy is high at cycles 1 through 7(128+L). done pulses at cycle 7(128+L)+1, with busy=0 in that cycle.
- With defaults (L=4): 924 busy cycles, done at cycle 925.
- A start held high through FIN is not accepted until the cycle after returning to IDLE.

## Test plan
- NTT layer 0 (inv=0): first issue -> rd_addr_a=0, b=128, tw_idx=1. p=127 -> a=127, b=255, tw_idx=1. The first wr_en comes 4 cycles after the first rd_en, with wr_addr_a=0, b=128.
- NTT layer 6: p=0 -> a=0, b=2, tw_idx=64. p=127 -> a=253, b=255, tw_idx=127.
- INTT (inv=1): layer 0, p=0 -> a=0, b=2, tw_idx=127, bf_mode=01. Layer 6, p=0 -> a=0, b=128, tw_idx=1.
- Full run at defaults:
  - Exactly 896 rd_en and 896 wr_en.
  - 4 idle cycles between layers.
  - Every index 0..255 is written exactly once per layer.
  - done is a single pulse at cycle 925.
- Start asserted at cycle 50 of a busy run -> no effect, same schedule. Reset pulled low at cycle 300 -> all outputs return to reset values the same cycle and the block remains IDLE.
- Parameter sweep RD_LAT=2, BF_LAT=5: writes trail reads by 7 cycles and done arrives at cycle 7·135+1 = 946.

Source files
------------

// File: rtl/ntt_sched.sv
// rtl/ntt_sched.sv - Kyber NTT/INTT layer sequencer: butterfly read addresses, twiddle index, aligned write-back.
module ntt_sched #(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inv,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_idx,
    output logic [1:0] bf_mode,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b
);
    localparam int L = RD_LAT + BF_LAT;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t      state_q, state_d;
    logic        inv_q, inv_d;
    logic [2:0]  layer_q, layer_d;
    logic [6:0]  p_q, p_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [16:0] wb_q [L];
    logic [16:0] wb_d [L];
    logic [6:0]  tw_q [RD_LAT];
    logic [6:0]  tw_d [RD_LAT];

    logic [2:0] s;
    logic [3:0] s4;
    logic [7:0] p8, len, hi, addr_a, addr_b;
    logic [6:0] tw_next;

    // Butterfly span for the current layer; the two transforms walk s in opposite directions.
    always_comb begin
        s       = inv_q ? (layer_q + 3'd1) : (3'd7 - layer_q);
        s4      = {1'b0, s};
        p8      = {1'b0, p_q};
        len     = 8'd1 << s;
        hi      = p8 >> s;
        addr_a  = (hi << (s4 + 4'd1)) | (p8 & (len - 8'd1));
        addr_b  = addr_a + len;
        tw_next = inv_q ? 7'((8'd1 << (4'd8 - s4)) - 8'd1 - hi)
                        : 7'((8'd1 << (3'd7 - s)) + hi);
    end

    always_comb begin
        state_d = state_q;
        inv_d   = inv_q;
        layer_d = layer_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    inv_d   = inv;
                    layer_d = 3'd0;
                    p_d     = 7'd0;
                end
            end
            S_ISSUE: begin
                p_d = p_q + 7'd1;
                if (p_q == 7'd127) begin
                    state_d = S_DRAIN;
                    cnt_d   = 8'(L - 1);
                end
            end
            S_DRAIN: begin
                // Hold off the next layer until its last write-back has landed.
                if (cnt_q == 8'd0) begin
                    if (layer_q == 3'd6) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_ISSUE;
                        layer_d = layer_q + 3'd1;
                        p_d     = 7'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_en     = (state_q == S_ISSUE);
    assign rd_addr_a = rd_en ? addr_a : 8'd0;
    assign rd_addr_b = rd_en ? addr_b : 8'd0;

    always_comb begin
        wb_d[0] = {rd_en, rd_addr_a, rd_addr_b};
        for (int i = 1; i < L; i++) begin
            wb_d[i] = wb_q[i-1];
        end
        tw_d[0] = rd_en ? tw_next : 7'd0;
        for (int i = 1; i < RD_LAT; i++) begin
            tw_d[i] = tw_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            inv_q   <= 1'b0;
            layer_q <= 3'd0;
            p_q     <= 7'd0;
            cnt_q   <= 8'd0;
            for (int i = 0; i < L; i++) wb_q[i] <= '0;
            for (int i = 0; i < RD_LAT; i++) tw_q[i] <= '0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            layer_q <= layer_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < L; i++) wb_q[i] <= wb_d[i];
            for (int i = 0; i < RD_LAT; i++) tw_q[i] <= tw_d[i];
        end
    end

    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done      = (state_q == S_FIN);
    assign bf_mode   = (state_q == S_IDLE) ? 2'b11 : {1'b0, inv_q};
    assign tw_idx    = tw_q[RD_LAT-1];
    assign wr_en     = wb_q[L-1][16];
    assign wr_addr_a = wb_q[L-1][15:8];
    assign wr_addr_b = wb_q[L-1][7:0];
endmodule
